// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer in front of an external alu_4bit.
// Holds one instruction, drives the ALU, commits result and flags.
module alu_op_sequencer #(
  parameter  int NREG = 4,
  parameter  int DW   = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_ld,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_dst,
  input  logic [AW-1:0] in_srca,
  input  logic [AW-1:0] in_srcb,
  input  logic [DW-1:0] in_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  input  logic          alu_zero,
  output logic          done_valid,
  output logic [DW-1:0] done_result,
  output logic          flag_c,
  output logic          flag_z,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ld_q, ld_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] srca_q, srca_d;
  logic [AW-1:0] srcb_q, srcb_d;
  logic [DW-1:0] res_q, res_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_z_q, flag_z_d;
  logic          done_valid_q, done_valid_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];

  // Next-state: accept in IDLE, sample ALU in EXEC, commit in WB.
  always_comb begin
    state_d      = state_q;
    ld_d         = ld_q;
    op_d         = op_q;
    dst_d        = dst_q;
    srca_d       = srca_q;
    srcb_d       = srcb_q;
    res_d        = res_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    flag_c_d     = flag_c_q;
    flag_z_d     = flag_z_q;
    done_valid_d = 1'b0;
    rf_d         = rf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          ld_d   = in_ld;
          op_d   = in_op;
          dst_d  = in_dst;
          srca_d = in_srca;
          srcb_d = in_srcb;
          if (in_ld) begin
            res_d        = in_imm;
            done_valid_d = 1'b1;
            state_d      = WB;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        res_d        = alu_out;
        carry_d      = alu_carry;
        zero_d       = alu_zero;
        done_valid_d = 1'b1;
        state_d      = WB;
      end
      WB: begin
        rf_d[dst_q] = res_q;
        if (!ld_q) begin
          flag_z_d = zero_q;
          if (op_q[2:1] == 2'b00) begin
            flag_c_d = carry_q;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, instruction, result, flags and register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ld_q         <= 1'b0;
      op_q         <= '0;
      dst_q        <= '0;
      srca_q       <= '0;
      srcb_q       <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      done_valid_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ld_q         <= ld_d;
      op_q         <= op_d;
      dst_q        <= dst_d;
      srca_q       <= srca_d;
      srcb_q       <= srcb_d;
      res_q        <= res_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      flag_c_q     <= flag_c_d;
      flag_z_q     <= flag_z_d;
      done_valid_q <= done_valid_d;
      rf_q         <= rf_d;
    end
  end

  // ALU operands only during EXEC, zero otherwise.
  always_comb begin
    in_ready = (state_q == IDLE);
    alu_a    = '0;
    alu_b    = '0;
    alu_sel  = 3'b000;
    if (state_q == EXEC) begin
      alu_a   = rf_q[srca_q];
      alu_b   = rf_q[srcb_q];
      alu_sel = op_q;
    end
  end

  assign done_valid  = done_valid_q;
  assign done_result = res_q;
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
  assign rd_data     = rf_q[rd_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural alu_4bit.
// Expected writebacks are queued at issue and popped on done_valid.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_ld;
  logic [2:0] in_op;
  logic [1:0] in_dst;
  logic [1:0] in_srca;
  logic [1:0] in_srcb;
  logic [3:0] in_imm;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_carry;
  logic       alu_zero;
  logic       done_valid;
  logic [3:0] done_result;
  logic       flag_c;
  logic       flag_z;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;

  int n_chk;
  int n_fail;

  logic [3:0] sb [$];
  logic [3:0] rf_m [4];
  logic       c_m;
  logic       z_m;

  alu_op_sequencer #(.NREG(4), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ld(in_ld), .in_op(in_op),
    .in_dst(in_dst), .in_srca(in_srca),
    .in_srcb(in_srcb), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_carry(alu_carry), .alu_zero(alu_zero),
    .done_valid(done_valid),
    .done_result(done_result),
    .flag_c(flag_c), .flag_z(flag_z),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {carry, zero, out}
  function automatic logic [5:0] alu_m(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [2:0] sel
  );
    logic [4:0] s;
    logic [3:0] o;
    logic       c;
    s = {1'b0, a} + {1'b0, b};
    o = '0;
    c = 1'b0;
    case (sel)
      3'd0: begin o = s[3:0]; c = s[4]; end
      3'd1: begin o = a - b; c = (a < b); end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: o = ~a;
      3'd6: begin o = {a[2:0], 1'b0}; c = a[3]; end
      default: begin o = {1'b0, a[3:1]}; c = a[0]; end
    endcase
    return {c, (o == 4'd0), o};
  endfunction

  always_comb {alu_carry, alu_zero, alu_out} = alu_m(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard pop on every writeback pulse.
  always @(negedge clk) begin
    if (rst_n && done_valid) begin
      if (sb.size() == 0) begin
        check("sb_extra", sb.size(), 1);
      end else begin
        check("done_res", done_result, sb.pop_front());
      end
    end
  end

  task automatic check_rf();
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check("rd_data", rd_data, rf_m[i]);
    end
  endtask

  task automatic model_op(input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] sa, input logic [1:0] sb_i);
    logic [5:0] r;
    r = alu_m(rf_m[sa], rf_m[sb_i], op);
    z_m = r[4];
    if (op == 3'd0 || op == 3'd1) c_m = r[5];
    rf_m[dst] = r[3:0];
    sb.push_back(r[3:0]);
  endtask

  // Issue one instruction, check handshake, latency and ALU drive.
  task automatic issue(input logic ld, input logic [2:0] op,
                       input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb_i, input logic [3:0] imm);
    int w;
    bit seen;
    logic [3:0] va;
    logic [3:0] vb;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("rdy_timeout", 0, 1);
      return;
    end
    va = rf_m[sa];
    vb = rf_m[sb_i];
    in_valid = 1'b1;
    in_ld    = ld;
    in_op    = op;
    in_dst   = dst;
    in_srca  = sa;
    in_srcb  = sb_i;
    in_imm   = imm;
    if (ld) begin
      rf_m[dst] = imm;
      sb.push_back(imm);
    end else begin
      model_op(op, dst, sa, sb_i);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0;
    for (int n = 1; n <= 4 && !seen; n++) begin
      @(negedge clk);
      check("alu_sel", alu_sel, (!ld && n == 1) ? op : 3'd0);
      if (!ld && n == 1) begin
        check("alu_a", alu_a, va);
        check("alu_b", alu_b, vb);
      end
      if (done_valid) begin
        seen = 1;
        check("latency", n, ld ? 1 : 2);
      end
    end
    if (!seen) check("no_done", 0, 1);
    @(negedge clk);
    check("flag_c", flag_c, c_m);
    check("flag_z", flag_z, z_m);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    c_m = 1'b0;
    z_m = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_ld    = 1'b0;
    in_op    = '0;
    in_dst   = '0;
    in_srca  = '0;
    in_srcb  = '0;
    in_imm   = '0;
    rd_addr  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_c", flag_c, 0);
    check("rst_z", flag_z, 0);
    check("rst_done", done_valid, 0);
    check("rst_res", done_result, 0);
    check_rf();

    // add 3+5
    issue(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd3);
    issue(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd5);
    issue(0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0);
    check_rf();

    // add with carry, then AND to zero keeps C
    issue(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd12);
    issue(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd5);
    issue(0, 3'd0, 2'd3, 2'd0, 2'd1, 4'd0);
    issue(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3);
    issue(0, 3'd2, 2'd2, 2'd0, 2'd1, 4'd0);
    check_rf();

    // sub with dst == srca
    issue(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd8);
    issue(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3);
    issue(0, 3'd1, 2'd0, 2'd0, 2'd1, 4'd0);
    check_rf();

    // shift whose ALU carry is 1 must not touch C; also xor, shr
    issue(1, 3'd0, 2'd3, 2'd0, 2'd0, 4'd9);
    issue(0, 3'd6, 2'd2, 2'd3, 2'd3, 4'd0);
    issue(0, 3'd4, 2'd1, 2'd3, 2'd3, 4'd0);
    issue(0, 3'd7, 2'd1, 2'd3, 2'd0, 4'd0);
    check_rf();

    // back-to-back with in_valid held
    issue(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd1);
    issue(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd1);
    in_valid = 1'b1;
    in_ld    = 1'b0;
    in_op    = 3'd0;
    in_dst   = 2'd0;
    in_srca  = 2'd0;
    in_srcb  = 2'd1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      check("ready_pat", in_ready, (i % 3 == 0) ? 1 : 0);
      if (i % 3 == 0) model_op(3'd0, 2'd0, 2'd0, 2'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("sb_drain", sb.size(), 0);
    check("b2b_c", flag_c, c_m);
    check("b2b_z", flag_z, z_m);
    check_rf();

    // set C, then abort an ADD r2 in EXEC
    issue(1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd15);
    issue(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3);
    issue(0, 3'd0, 2'd3, 2'd0, 2'd1, 4'd0);
    issue(0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0);
    check_rf();
    in_valid = 1'b1;
    in_ld    = 1'b0;
    in_op    = 3'd0;
    in_dst   = 2'd2;
    in_srca  = 2'd3;
    in_srcb  = 2'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("abort_exec", in_ready, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_rdy", in_ready, 1);
    check("abort_dv", done_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_dv", done_valid, 0);
      check("post_rst_rdy", in_ready, 1);
    end
    check("post_rst_c", flag_c, 0);
    check("post_rst_z", flag_z, 0);
    check("post_rst_res", done_result, 0);
    check_rf();

    // still operational after reset
    issue(1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd6);
    issue(0, 3'd3, 2'd1, 2'd2, 2'd0, 4'd0);
    check_rf();
    check("sb_final", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
